// File: rtl/grf_scoreboard_if.sv
// Issue/retire/status bundle between the decode and writeback stages and the
// GRF write scoreboard.
interface grf_scoreboard_if #(
  parameter int CNT_W = 2
);
  // Decode-stage issue request
  logic             IssueValid;
  logic [4:0]       Rs;
  logic [4:0]       Rt;
  logic             UseRs;
  logic             UseRt;
  logic [4:0]       Rd;
  logic             RegDst;
  logic             WriteEn;
  logic             JL;

  // Writeback retire and pipeline control
  logic             RetireValid;
  logic [4:0]       RetireReg;
  logic             Flush;

  // Scoreboard status
  logic             Stall;
  logic             Issued;
  logic [31:0]      Busy;
  logic [CNT_W+4:0] PendingCount;
  logic             Underflow;

  modport master (
    output IssueValid, Rs, Rt, UseRs, UseRt, Rd, RegDst, WriteEn, JL,
    output RetireValid, RetireReg, Flush,
    input  Stall, Issued, Busy, PendingCount, Underflow
  );

  modport slave (
    input  IssueValid, Rs, Rt, UseRs, UseRt, Rd, RegDst, WriteEn, JL,
    input  RetireValid, RetireReg, Flush,
    output Stall, Issued, Busy, PendingCount, Underflow
  );
endinterface

// File: rtl/grf_scoreboard.sv
// Per-register pending-write scoreboard for the pipelined MIPS core: stalls
// decode on RAW hazards against in-flight writes and on counter saturation.
module grf_scoreboard #(
  parameter int CNT_W = 2
) (
  input logic              clk,
  input logic              Reset,
  grf_scoreboard_if.slave  sb
);

  localparam int PEND_W  = CNT_W + 5;
  localparam int MAX_CNT = (1 << CNT_W) - 1;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [PEND_W-1:0] pend_t;

  cnt_t        cnt      [32];
  cnt_t        cntNext  [32];
  logic [31:0] busyQ;
  logic [31:0] busyNext;
  pend_t       pendQ;
  pend_t       pendNext;
  logic        underflowQ;

  logic [4:0]  dest;
  logic        destTracked;
  logic        hazard;
  logic        saturated;
  logic        stall;
  logic        issued;
  logic [31:0] incVec;
  logic [31:0] decVec;
  logic        underflowHit;

  // Destination select mirrors the GRF write-port mux.
  always_comb begin
    dest        = sb.JL ? 5'd31 : (sb.RegDst ? sb.Rd : sb.Rt);
    destTracked = sb.WriteEn & (dest != 5'd0);
  end

  // Hazard looks only at registered Busy: a retire in the same cycle does not
  // release a waiting reader until the following cycle.
  always_comb begin
    hazard    = (sb.UseRs & (sb.Rs != 5'd0) & busyQ[sb.Rs])
              | (sb.UseRt & (sb.Rt != 5'd0) & busyQ[sb.Rt]);
    saturated = destTracked & (cnt[dest] == cnt_t'(MAX_CNT));
    stall     = sb.IssueValid & (~Reset | hazard | saturated);
    issued    = sb.IssueValid & ~stall & ~sb.Flush;
  end

  // NOTE: every always_comb output gets a default before the loop so no
  // path leaves a variable unassigned and a latch can never be inferred.
  always_comb begin
    incVec   = '0;
    decVec   = '0;
    busyNext = '0;
    for (int n = 0; n < 32; n++) begin
      cntNext[n] = cnt[n];
    end
    for (int n = 1; n < 32; n++) begin
      incVec[n]   = issued & destTracked & (dest == 5'(n));
      decVec[n]   = sb.RetireValid & (sb.RetireReg == 5'(n))
                  & ((cnt[n] != '0) | incVec[n]);
      cntNext[n]  = cnt[n] + cnt_t'(incVec[n]) - cnt_t'(decVec[n]);
      busyNext[n] = (cntNext[n] != '0);
    end
  end

  always_comb begin
    pendNext     = pendQ + pend_t'(|incVec) - pend_t'(|decVec);
    underflowHit = sb.RetireValid & (sb.RetireReg != 5'd0)
                 & (cnt[sb.RetireReg] == '0) & ~incVec[sb.RetireReg]
                 & ~sb.Flush;
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  // NOTE: the counter array is reset explicitly; it is only 32 small
  // counters in flops, and Busy/Stall depend on it being defined.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      for (int n = 0; n < 32; n++) begin
        cnt[n] <= '0;
      end
      busyQ      <= '0;
      pendQ      <= '0;
      underflowQ <= 1'b0;
    end else if (sb.Flush) begin
      for (int n = 0; n < 32; n++) begin
        cnt[n] <= '0;
      end
      busyQ <= '0;
      pendQ <= '0;
    end else begin
      for (int n = 0; n < 32; n++) begin
        cnt[n] <= cntNext[n];
      end
      busyQ      <= busyNext;
      pendQ      <= pendNext;
      underflowQ <= underflowQ | underflowHit;
    end
  end

  assign sb.Stall        = stall;
  assign sb.Issued       = issued;
  assign sb.Busy         = busyQ;
  assign sb.PendingCount = pendQ;
  assign sb.Underflow    = underflowQ;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed self-checking bench for grf_scoreboard with CNT_W=2.
module tb_grf_scoreboard;

  localparam int CNT_W = 2;

  logic clk;
  logic Reset;
  int   nChecks;
  int   nPass;

  grf_scoreboard_if #(.CNT_W(CNT_W)) sbIf ();

  grf_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .Reset (Reset),
    .sb    (sbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic setIssue(input logic v, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                          input logic rdst, input logic we, input logic jl);
    sbIf.IssueValid = v;
    sbIf.Rs         = rs;
    sbIf.UseRs      = urs;
    sbIf.Rt         = rt;
    sbIf.UseRt      = urt;
    sbIf.Rd         = rd;
    sbIf.RegDst     = rdst;
    sbIf.WriteEn    = we;
    sbIf.JL         = jl;
  endtask

  task automatic setRetire(input logic v, input logic [4:0] r);
    sbIf.RetireValid = v;
    sbIf.RetireReg   = r;
  endtask

  // Advance one edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // R-type write to rd, no source reads.
  task automatic writeRd(input logic [4:0] rd);
    setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idleIssue();
    setIssue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    Reset   = 1'b0;
    sbIf.Flush = 1'b0;
    setRetire(1'b0, 5'd0);
    writeRd(5'd8);

    // Reset held for two edges with an instruction presented
    #1;
    check("rst_stall", sbIf.Stall, 1);
    check("rst_issued", sbIf.Issued, 0);
    step();
    step();
    check("rst_busy", sbIf.Busy, 0);
    check("rst_pend", sbIf.PendingCount, 0);
    check("rst_uflow", sbIf.Underflow, 0);
    Reset = 1'b1;
    idleIssue();
    step();
    check("rel_busy", sbIf.Busy, 0);
    check("rel_pend", sbIf.PendingCount, 0);

    // Write then read of $8
    writeRd(5'd8);
    #1;
    check("w8_issued", sbIf.Issued, 1);
    check("w8_stall", sbIf.Stall, 0);
    step();
    check("w8_busy", sbIf.Busy[8], 1);
    check("w8_pend", sbIf.PendingCount, 1);
    setIssue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("r8_stall", sbIf.Stall, 1);
    check("r8_issued", sbIf.Issued, 0);
    step();
    setRetire(1'b1, 5'd8);
    #1;
    check("r8_nobypass", sbIf.Stall, 1);
    step();
    setRetire(1'b0, 5'd0);
    check("r8_busy_clr", sbIf.Busy[8], 0);
    check("r8_pend_clr", sbIf.PendingCount, 0);
    #1;
    check("r8_released", sbIf.Issued, 1);
    step();
    idleIssue();

    // JL writes $31 regardless of Rd
    setIssue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
    step();
    check("jl_busy31", sbIf.Busy[31], 1);
    check("jl_busy5", sbIf.Busy[5], 0);
    check("jl_pend", sbIf.PendingCount, 1);
    setIssue(1'b1, 5'd0, 1'b0, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("r31_stall", sbIf.Stall, 1);
    setRetire(1'b1, 5'd31);
    step();
    setRetire(1'b0, 5'd0);
    check("r31_busy_clr", sbIf.Busy[31], 0);
    #1;
    check("r31_released", sbIf.Stall, 0);
    idleIssue();

    // Register 0 is never tracked and never hazards
    setIssue(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
    setRetire(1'b1, 5'd0);
    #1;
    check("r0_issued", sbIf.Issued, 1);
    step();
    setRetire(1'b0, 5'd0);
    check("r0_busy", sbIf.Busy, 0);
    check("r0_pend", sbIf.PendingCount, 0);
    check("r0_uflow", sbIf.Underflow, 0);

    // Saturation of $3 at 2^CNT_W-1
    writeRd(5'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sat_fill_issued", sbIf.Issued, 1);
      step();
    end
    check("sat_pend3", sbIf.PendingCount, 3);
    #1;
    check("sat_stall", sbIf.Stall, 1);
    setRetire(1'b1, 5'd3);
    #1;
    check("sat_stall_retire", sbIf.Stall, 1);
    step();
    setRetire(1'b0, 5'd0);
    check("sat_pend2", sbIf.PendingCount, 2);
    #1;
    check("sat_reissue", sbIf.Issued, 1);
    step();
    check("sat_pend_back3", sbIf.PendingCount, 3);
    idleIssue();
    setRetire(1'b1, 5'd3);
    step();
    check("sat_drain_pend", sbIf.PendingCount, 2);
    writeRd(5'd3);
    #1;
    check("same_issued", sbIf.Issued, 1);
    step();
    check("same_pend", sbIf.PendingCount, 2);
    check("same_busy3", sbIf.Busy[3], 1);
    idleIssue();
    step();
    step();
    setRetire(1'b0, 5'd0);
    check("sat_empty", sbIf.PendingCount, 0);

    // Same-cycle issue and retire on an idle register: no underflow
    writeRd(5'd10);
    setRetire(1'b1, 5'd10);
    step();
    idleIssue();
    setRetire(1'b0, 5'd0);
    check("idle_same_busy", sbIf.Busy[10], 0);
    check("idle_same_pend", sbIf.PendingCount, 0);
    check("idle_same_uflow", sbIf.Underflow, 0);

    // Flush with four writes pending, then underflow
    for (int r = 9; r < 13; r++) begin
      writeRd(5'(r));
      step();
    end
    check("fl_pend4", sbIf.PendingCount, 4);
    writeRd(5'd13);
    setRetire(1'b1, 5'd9);
    sbIf.Flush = 1'b1;
    #1;
    check("fl_issued", sbIf.Issued, 0);
    step();
    sbIf.Flush = 1'b0;
    idleIssue();
    setRetire(1'b0, 5'd0);
    check("fl_pend", sbIf.PendingCount, 0);
    check("fl_busy", sbIf.Busy, 0);
    check("fl_uflow", sbIf.Underflow, 0);
    setRetire(1'b1, 5'd9);
    step();
    setRetire(1'b0, 5'd0);
    check("uf_set", sbIf.Underflow, 1);
    check("uf_pend", sbIf.PendingCount, 0);
    sbIf.Flush = 1'b1;
    step();
    sbIf.Flush = 1'b0;
    step();
    check("uf_sticky", sbIf.Underflow, 1);
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    check("uf_reset", sbIf.Underflow, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
